mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
Load/store unit for the MEM stage of the RV32 pipeline, directly downstream of the execute stage. It takes the effective address, store data and lsu_op produced by execute and runs one transaction at a time on a req/ack data-memory port. It handles byte-lane alignment, store data replication, load sign/zero extension and misalignment detection. It asserts busy so core control can stall the pipeline while an access is outstanding.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in REQ waiting for dmem_ack before a timeout error; 0 disables the timeout
TCNT_W, 5, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  core clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
lsu_start  in  1  one-cycle request from execute; accepted only in IDLE
lsu_we  in  1  1 = store, 0 = load
lsu_op  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only)
lsu_addr  in  32  effective byte address (mem_wb_addr from execute)
lsu_wdata  in  32  store source data (mem_wb_data from execute)
lsu_busy  out  1  high while state != IDLE
lsu_done  out  1  one-cycle pulse when a transaction completes, including error completions
lsu_err  out  1  one-cycle pulse together with lsu_done on an error completion
lsu_err_cause  out  2  00 none, 01 misaligned, 10 illegal op, 11 bus timeout; valid when lsu_done is high
lsu_rdata  out  32  formatted load result; holds until the next completion
dmem_req  out  1  bus request; held high until ack or timeout
dmem_we  out  1  bus write enable
dmem_addr  out  32  word-aligned address: {addr[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_rdata  in  32  read data; valid in the cycle dmem_ack is high
dmem_ack  in  1  transfer complete

Behaviour:
- FSM states: IDLE, REQ, ERR.
- Reset: state IDLE; all outputs 0; timeout counter 0.
- Reset asserted in REQ drops dmem_req at that edge; no lsu_done is produced.
- IDLE with lsu_start=1: register we, op, addr and wdata, then classify.
  - Illegal op: store with op not in {000,001,010}, or load with op in {011,110,111}. Go to ERR, cause 10.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0. Go to ERR, cause 01.
  - Illegal op takes priority over misaligned.
  - Otherwise go to REQ; dmem_* outputs are registered and valid in the first REQ cycle.
- ERR lasts one cycle: lsu_done=1, lsu_err=1, no bus request, lsu_rdata unchanged, then IDLE.
- lsu_start is ignored while busy.
- REQ:
  - dmem_req=1; addr, we, be and wdata stay stable.
  - dmem_ack is sampled each cycle; ack is allowed in the first REQ cycle.
  - On ack: dmem_req drops at the edge; next cycle lsu_done=1 and state is IDLE.
  - Loads: lsu_rdata updated in the same cycle as lsu_done.
  - Stores: lsu_rdata set to 0.
- Minimum latency: lsu_start in cycle N, dmem_req in N+1, ack in N+1, lsu_done in N+2. lsu_busy is high in N+1 and N+2 and low in N+3.
- Timeout: the counter increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES, drop dmem_req and produce done+err with cause 11. The counter clears on leaving REQ.
- dmem_ack seen outside REQ is ignored.
- Store formatting, with lane = addr[1:0]:
  - B: wdata = {4{wdata[7:0]}}, be = 4'b0001 << lane.
  - H: wdata = {2{wdata[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - W: wdata passed through, be = 4'b1111.
- Loads drive be as for the same access size.
- Load formatting:
  - Select byte rdata[8*lane+:8], or halfword rdata[16*addr[1]+:16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.

Test Plan:
- Reset mid-REQ (LW issued, no ack, rst for 1 cycle) -> dmem_req=0, busy=0, no lsu_done, lsu_rdata=0.
- LB addr 0x1003, ack in first REQ cycle with rdata 0x80FF_1234 -> dmem_addr 0x1000, be 1000, done at N+2, lsu_rdata 0xFFFF_FF80; the same access as LBU gives 0x0000_0080.
- SH addr 0x2002, wdata 0xDEAD_BEEF, ack after 3 cycles -> be 1100, dmem_wdata 0xBEEF_BEEF, dmem_we=1, req stable for 3 cycles, done one cycle after ack.
- LW addr 0x3001 -> no dmem_req, done+err with cause 01 one cycle after start; store with op 100 -> cause 10.
- LW with no ack and TIMEOUT_CYCLES=16 -> req high for exactly 16 cycles, then done+err with cause 11; a later stray ack is ignored.
- lsu_start pulsed while busy -> ignored; exactly one dmem_req transaction and one lsu_done.

Source files
------------

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: runs one aligned data-memory transaction at a time
// on a req/ack port, with lane steering, store replication and load extension.
module mem_lsu #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TCNT_W         = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_start,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_op,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [1:0]  lsu_err_cause,
  output logic [31:0] lsu_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  typedef enum logic [1:0] {IDLE, REQ, ERR} state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_MISAL = 2'b01;
  localparam logic [1:0] CAUSE_ILLOP = 2'b10;
  localparam logic [1:0] CAUSE_TMO   = 2'b11;

  // Last REQ cycle count at which a missing ack becomes a timeout.
  localparam logic [TCNT_W-1:0] TLIM =
    TCNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

  state_t            state, state_nxt;
  logic [TCNT_W-1:0] tcnt, tcnt_nxt;

  logic [2:0] op_q;
  logic [1:0] lane_q;
  logic       we_q;

  logic       accept, op_illegal, op_misal, tmo_hit;
  logic       bus_load, req_nxt, done_nxt, err_nxt, rdata_load;
  logic [1:0] cause_nxt;

  function automatic logic [3:0] be_fmt(input logic [2:0] op, input logic [1:0] lane);
    case (op[1:0])
      2'b00:   be_fmt = 4'b0001 << lane;
      2'b01:   be_fmt = lane[1] ? 4'b1100 : 4'b0011;
      default: be_fmt = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_fmt(input logic [2:0] op, input logic [31:0] wd);
    case (op[1:0])
      2'b00:   st_fmt = {4{wd[7:0]}};
      2'b01:   st_fmt = {2{wd[15:0]}};
      default: st_fmt = wd;
    endcase
  endfunction

  function automatic logic [31:0] ld_fmt(input logic [2:0] op, input logic [1:0] lane,
                                         input logic [31:0] rd);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    b   = rd[8*lane +: 8];
    h   = rd[16*lane[1] +: 16];
    ext = '0;
    case (op)
      3'b000:  ext = b;
      3'b001:  ext = h;
      3'b100:  ext = {24'd0, b};
      3'b101:  ext = {16'd0, h};
      default: ext = rd;
    endcase
    ld_fmt = ext;
  endfunction

  // The done cycle still counts as busy, so a start there is dropped too.
  assign lsu_busy = (state != IDLE) || lsu_done;
  assign accept   = (state == IDLE) && !lsu_done && lsu_start;
  assign tmo_hit  = TMO_EN && (tcnt == TLIM);

  always_comb begin
    op_illegal = 1'b0;
    if (lsu_we)
      op_illegal = !(lsu_op == 3'b000 || lsu_op == 3'b001 || lsu_op == 3'b010);
    else
      op_illegal = (lsu_op == 3'b011 || lsu_op == 3'b110 || lsu_op == 3'b111);
    op_misal = ((lsu_op[1:0] == 2'b01) && lsu_addr[0]) ||
               ((lsu_op[1:0] == 2'b10) && (lsu_addr[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (op_illegal || op_misal) ? ERR : REQ;
      REQ:     if (dmem_ack || tmo_hit) state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_load   = 1'b0;
    req_nxt    = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    cause_nxt  = CAUSE_NONE;
    rdata_load = 1'b0;
    tcnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op_illegal) begin
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
            cause_nxt = CAUSE_ILLOP;
          end else if (op_misal) begin
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
            cause_nxt = CAUSE_MISAL;
          end else begin
            bus_load = 1'b1;
            req_nxt  = 1'b1;
          end
        end
      end
      REQ: begin
        if (dmem_ack) begin
          done_nxt   = 1'b1;
          rdata_load = 1'b1;
        end else if (tmo_hit) begin
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
          cause_nxt = CAUSE_TMO;
        end else begin
          req_nxt  = 1'b1;
          tcnt_nxt = tcnt + TCNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Control and visible outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt          <= '0;
      lsu_done      <= 1'b0;
      lsu_err       <= 1'b0;
      lsu_err_cause <= CAUSE_NONE;
      lsu_rdata     <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_be       <= '0;
      dmem_wdata    <= '0;
    end else begin
      tcnt          <= tcnt_nxt;
      lsu_done      <= done_nxt;
      lsu_err       <= err_nxt;
      lsu_err_cause <= cause_nxt;
      dmem_req      <= req_nxt;
      if (bus_load) begin
        dmem_we    <= lsu_we;
        dmem_addr  <= {lsu_addr[31:2], 2'b00};
        dmem_be    <= be_fmt(lsu_op, lsu_addr[1:0]);
        dmem_wdata <= st_fmt(lsu_op, lsu_wdata);
      end
      if (rdata_load)
        lsu_rdata <= we_q ? 32'd0 : ld_fmt(op_q, lane_q, dmem_rdata);
    end
  end

  // Transaction context used for load formatting at ack time
  always_ff @(posedge clk) begin
    if (bus_load) begin
      op_q   <= lsu_op;
      lane_q <= lsu_addr[1:0];
      we_q   <= lsu_we;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: hand-computed vectors, outputs sampled on the falling edge.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_start;
  logic        lsu_we;
  logic [2:0]  lsu_op;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_busy;
  logic        lsu_done;
  logic        lsu_err;
  logic [1:0]  lsu_err_cause;
  logic [31:0] lsu_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int req_rise = 0;
  logic req_q = 1'b0;

  mem_lsu #(.TIMEOUT_CYCLES(16), .TCNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .lsu_start(lsu_start), .lsu_we(lsu_we), .lsu_op(lsu_op),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_err(lsu_err),
    .lsu_err_cause(lsu_err_cause), .lsu_rdata(lsu_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (lsu_done) done_cnt <= done_cnt + 1;
    if (dmem_req && !req_q) req_rise <= req_rise + 1;
    req_q <= dmem_req;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives lsu_start for one cycle; returns at the falling edge of the following cycle.
  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata);
    @(negedge clk);
    lsu_start = 1'b1;
    lsu_we    = we;
    lsu_op    = op;
    lsu_addr  = addr;
    lsu_wdata = wdata;
    @(negedge clk);
    lsu_start = 1'b0;
  endtask

  // Load acked in the first REQ cycle; checks bus fields and formatted result.
  task automatic load_fast(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rd, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_rdata);
    issue(1'b0, op, addr, 32'h0);
    check({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
    check({tag, "_addr"}, dmem_addr, exp_addr);
    check({tag, "_be"}, {28'd0, dmem_be}, {28'd0, exp_be});
    dmem_ack   = 1'b1;
    dmem_rdata = rd;
    @(negedge clk);
    dmem_ack = 1'b0;
    check({tag, "_done"}, {31'd0, lsu_done}, 32'd1);
    check({tag, "_busy_n2"}, {31'd0, lsu_busy}, 32'd1);
    check({tag, "_rdata"}, lsu_rdata, exp_rdata);
    @(negedge clk);
    check({tag, "_busy_n3"}, {31'd0, lsu_busy}, 32'd0);
  endtask

  initial begin
    int dc0, rr0, nreq;
    rst = 1'b1; lsu_start = 1'b0; lsu_we = 1'b0; lsu_op = 3'b000;
    lsu_addr = '0; lsu_wdata = '0; dmem_rdata = '0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, lsu_busy}, 32'd0);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_done", {31'd0, lsu_done}, 32'd0);
    check("rst_rdata", lsu_rdata, 32'd0);

    load_fast("lb",  3'b000, 32'h0000_1003, 32'h80FF_1234, 32'h0000_1000, 4'b1000, 32'hFFFF_FF80);
    load_fast("lbu", 3'b100, 32'h0000_1003, 32'h80FF_1234, 32'h0000_1000, 4'b1000, 32'h0000_0080);
    load_fast("lh",  3'b001, 32'h0000_1002, 32'h80FF_1234, 32'h0000_1000, 4'b1100, 32'hFFFF_80FF);
    load_fast("lhu", 3'b101, 32'h0000_1002, 32'h80FF_1234, 32'h0000_1000, 4'b1100, 32'h0000_80FF);
    load_fast("lb1", 3'b000, 32'h0000_1001, 32'h80FF_1234, 32'h0000_1000, 4'b0010, 32'h0000_0012);
    load_fast("lw",  3'b010, 32'h0000_1004, 32'h80FF_1234, 32'h0000_1004, 4'b1111, 32'h80FF_1234);
    load_fast("lbu0", 3'b100, 32'h0000_1000, 32'h1234_56A5, 32'h0000_1000, 4'b0001, 32'h0000_00A5);

    // Misaligned word load: error one cycle after start, rdata untouched.
    rr0 = req_rise;
    issue(1'b0, 3'b010, 32'h0000_3001, 32'h0);
    check("mis_req", {31'd0, dmem_req}, 32'd0);
    check("mis_done", {31'd0, lsu_done}, 32'd1);
    check("mis_err", {31'd0, lsu_err}, 32'd1);
    check("mis_cause", {30'd0, lsu_err_cause}, 32'd1);
    check("mis_rdata", lsu_rdata, 32'h0000_00A5);
    @(negedge clk);
    check("mis_done_clr", {31'd0, lsu_done}, 32'd0);

    // Store with a load-only op; illegal wins over misalignment too.
    issue(1'b1, 3'b100, 32'h0000_3000, 32'h1);
    check("ill_done", {31'd0, lsu_done}, 32'd1);
    check("ill_cause", {30'd0, lsu_err_cause}, 32'd2);
    @(negedge clk);
    issue(1'b1, 3'b101, 32'h0000_3001, 32'h1);
    check("ill_prio_cause", {30'd0, lsu_err_cause}, 32'd2);
    issue(1'b0, 3'b110, 32'h0000_3000, 32'h0);
    check("ill_ld_cause", {30'd0, lsu_err_cause}, 32'd2);
    @(negedge clk);
    check("err_no_req", req_rise - rr0, 32'd0);

    // Reset while a word load waits for ack.
    load_fast("lw2", 3'b010, 32'h0000_0100, 32'hCAFE_F00D, 32'h0000_0100, 4'b1111, 32'hCAFE_F00D);
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    dc0 = done_cnt;
    check("rreq_req", {31'd0, dmem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rreq_req0", {31'd0, dmem_req}, 32'd0);
    check("rreq_busy", {31'd0, lsu_busy}, 32'd0);
    check("rreq_done", {31'd0, lsu_done}, 32'd0);
    check("rreq_rdata", lsu_rdata, 32'd0);
    @(negedge clk);
    check("rreq_no_done", done_cnt - dc0, 32'd0);

    // Halfword store, ack in the third REQ cycle.
    issue(1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      check("sh_req", {31'd0, dmem_req}, 32'd1);
      check("sh_be", {28'd0, dmem_be}, 32'hC);
      check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
      check("sh_we", {31'd0, dmem_we}, 32'd1);
      check("sh_addr", dmem_addr, 32'h0000_2000);
      check("sh_nodone", {31'd0, lsu_done}, 32'd0);
      if (i == 2) dmem_ack = 1'b1;
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    check("sh_done", {31'd0, lsu_done}, 32'd1);
    check("sh_err", {31'd0, lsu_err}, 32'd0);
    check("sh_req0", {31'd0, dmem_req}, 32'd0);
    check("sh_rdata", lsu_rdata, 32'd0);
    @(negedge clk);

    // Byte store replication.
    issue(1'b1, 3'b000, 32'h0000_2001, 32'h1234_5678);
    check("sb_be", {28'd0, dmem_be}, 32'h2);
    check("sb_wdata", dmem_wdata, 32'h7878_7878);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    @(negedge clk);

    // Timeout: no ack at all.
    issue(1'b0, 3'b010, 32'h0000_4000, 32'h0);
    nreq = 0;
    for (int i = 0; i < 40 && dmem_req; i++) begin
      nreq++;
      check("tmo_nodone", {31'd0, lsu_done}, 32'd0);
      @(negedge clk);
    end
    check("tmo_req_cycles", nreq, 32'd16);
    check("tmo_done", {31'd0, lsu_done}, 32'd1);
    check("tmo_err", {31'd0, lsu_err}, 32'd1);
    check("tmo_cause", {30'd0, lsu_err_cause}, 32'd3);
    @(negedge clk);
    dc0 = done_cnt;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("stray_done", {31'd0, lsu_done}, 32'd0);
    check("stray_busy", {31'd0, lsu_busy}, 32'd0);
    check("stray_rdata", lsu_rdata, 32'h0000_0000);
    @(negedge clk);
    check("stray_cnt", done_cnt - dc0, 32'd0);

    // Start pulses while busy must be dropped.
    dc0 = done_cnt;
    rr0 = req_rise;
    issue(1'b0, 3'b010, 32'h0000_5000, 32'h0);
    lsu_start = 1'b1;
    lsu_addr  = 32'h0000_6000;
    @(negedge clk);
    lsu_start = 1'b0;
    check("busy_addr", dmem_addr, 32'h0000_5000);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("busy_done", {31'd0, lsu_done}, 32'd1);
    check("busy_rdata", lsu_rdata, 32'h1234_5678);
    lsu_start = 1'b1;
    @(negedge clk);
    lsu_start = 1'b0;
    check("busy_idle", {31'd0, lsu_busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("busy_one_req", req_rise - rr0, 32'd1);
    check("busy_one_done", done_cnt - dc0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
